map_ram: RTL and testbench

- Parametrised, writable successor to the fixed 16x16x2-bit map ROM.
- Holds the raycaster's world map in a synchronous RAM: two independent registered read ports (A: ray tracer, B: debug/overlay) and one write port for runtime map editing.
- An internal init sequencer fills a default bordered map after reset or on request.
- Sits between the tracer and the host/debug interface.

---
 rtl/map_pkg.sv | 22 ++
 rtl/map_ram_if.sv | 41 ++++
 rtl/map_ram_core.sv | 35 +++
 rtl/map_ram.sv | 113 +++++++++++
 tb/tb_map_ram.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/map_pkg.sv
// Shared definitions for the writable raycaster map RAM: default geometry,
// cell value constants, sequencer state encoding and the edge-cell test.
package map_pkg;

  localparam int DEF_COL_BITS = 4;
  localparam int DEF_ROW_BITS = 4;
  localparam int DEF_VAL_BITS = 2;

  localparam int CELL_EMPTY = 0;
  localparam int CELL_WALL  = 1;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } map_state_e;

  function automatic logic is_border(input int col, input int row,
                                     input int col_max, input int row_max);
    return (col == 0) || (col == col_max) || (row == 0) || (row == row_max);
  endfunction

endpackage

// File: rtl/map_ram_if.sv
// Tracer/debug read ports, edit write port and init control of the map RAM.
interface map_ram_if #(
  parameter int COL_BITS = 4,
  parameter int ROW_BITS = 4,
  parameter int VAL_BITS = 2
);
  logic                rd_a_en;
  logic [COL_BITS-1:0] rd_a_col;
  logic [ROW_BITS-1:0] rd_a_row;
  logic [VAL_BITS-1:0] rd_a_val;
  logic                rd_a_vld;

  logic                rd_b_en;
  logic [COL_BITS-1:0] rd_b_col;
  logic [ROW_BITS-1:0] rd_b_row;
  logic [VAL_BITS-1:0] rd_b_val;
  logic                rd_b_vld;

  logic                wr_en;
  logic [COL_BITS-1:0] wr_col;
  logic [ROW_BITS-1:0] wr_row;
  logic [VAL_BITS-1:0] wr_val;
  logic                wr_ready;

  logic                init_req;
  logic                init_busy;

  modport master (
    output rd_a_en, rd_a_col, rd_a_row, input rd_a_val, rd_a_vld,
    output rd_b_en, rd_b_col, rd_b_row, input rd_b_val, rd_b_vld,
    output wr_en, wr_col, wr_row, wr_val, input wr_ready,
    output init_req, input init_busy
  );

  modport slave (
    input rd_a_en, rd_a_col, rd_a_row, output rd_a_val, rd_a_vld,
    input rd_b_en, rd_b_col, rd_b_row, output rd_b_val, rd_b_vld,
    input wr_en, wr_col, wr_row, wr_val, output wr_ready,
    input init_req, output init_busy
  );
endinterface

// File: rtl/map_ram_core.sv
// Dual registered-read, single-write synchronous memory; a read colliding
// with a write to the same address returns the old contents.
module map_ram_core #(
  parameter int ADDR_BITS = 8,
  parameter int VAL_BITS  = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rd_a_en,
  input  logic [ADDR_BITS-1:0] rd_a_addr,
  output logic [VAL_BITS-1:0]  rd_a_data,
  input  logic                 rd_b_en,
  input  logic [ADDR_BITS-1:0] rd_b_addr,
  output logic [VAL_BITS-1:0]  rd_b_data,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [VAL_BITS-1:0]  wr_data
);
  logic [VAL_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output registers only take the reset; array contents are left alone.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_a_data <= '0;
      rd_b_data <= '0;
    end else begin
      if (rd_a_en) rd_a_data <= mem[rd_a_addr];
      if (rd_b_en) rd_b_data <= mem[rd_b_addr];
    end
  end
endmodule

// File: rtl/map_ram.sv
// Writable world map: init sequencer, write arbitration and read valids
// around map_ram_core. Optional edge lock: MAP_RAM_BORDER_LOCK_EN.
module map_ram
  import map_pkg::*;
#(
  parameter int COL_BITS   = DEF_COL_BITS,
  parameter int ROW_BITS   = DEF_ROW_BITS,
  parameter int VAL_BITS   = DEF_VAL_BITS,
  parameter int BORDER_VAL = CELL_WALL
) (
  input  logic      clk,
  input  logic      reset_n,
  map_ram_if.slave  bus
);
  localparam int ADDR_BITS = ROW_BITS + COL_BITS;
  localparam int COL_MAX   = 2**COL_BITS - 1;
  localparam int ROW_MAX   = 2**ROW_BITS - 1;
  localparam logic [VAL_BITS-1:0]  BORDER_V = VAL_BITS'(BORDER_VAL);
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  map_state_e           state_reg, state_next;
  logic [ADDR_BITS-1:0] cnt_reg, cnt_next;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [VAL_BITS-1:0]  mem_data;
  logic                 wr_allowed;
  logic                 vld_a_reg, vld_b_reg;
  logic [VAL_BITS-1:0]  core_a_data, core_b_data;

`ifdef MAP_RAM_BORDER_LOCK_EN
  logic lock_a_reg, lock_b_reg;
  assign wr_allowed = !is_border(int'(bus.wr_col), int'(bus.wr_row), COL_MAX, ROW_MAX);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_a_reg <= 1'b0;
      lock_b_reg <= 1'b0;
    end else begin
      if (bus.rd_a_en) lock_a_reg <= is_border(int'(bus.rd_a_col), int'(bus.rd_a_row), COL_MAX, ROW_MAX);
      if (bus.rd_b_en) lock_b_reg <= is_border(int'(bus.rd_b_col), int'(bus.rd_b_row), COL_MAX, ROW_MAX);
    end
  end

  assign bus.rd_a_val = lock_a_reg ? BORDER_V : core_a_data;
  assign bus.rd_b_val = lock_b_reg ? BORDER_V : core_b_data;
`else
  assign wr_allowed   = 1'b1;
  assign bus.rd_a_val = core_a_data;
  assign bus.rd_b_val = core_b_data;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= INIT;
      cnt_reg   <= '0;
      vld_a_reg <= 1'b0;
      vld_b_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      vld_a_reg <= bus.rd_a_en;
      vld_b_reg <= bus.rd_b_en;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    mem_we     = 1'b0;
    mem_addr   = {bus.wr_row, bus.wr_col};
    mem_data   = bus.wr_val;
    unique case (state_reg)
      INIT: begin
        mem_we   = 1'b1;
        mem_addr = cnt_reg;
        mem_data = is_border(int'(cnt_reg[COL_BITS-1:0]), int'(cnt_reg[ADDR_BITS-1:COL_BITS]),
                             COL_MAX, ROW_MAX) ? BORDER_V : VAL_BITS'(CELL_EMPTY);
        // Counter wraps to zero naturally after the last cell.
        cnt_next = cnt_reg + 1'b1;
        if (bus.init_req) cnt_next = '0;
        else if (cnt_reg == LAST_ADDR) state_next = READY;
      end
      READY: begin
        if (bus.init_req) begin
          state_next = INIT;
          cnt_next   = '0;
        end else begin
          mem_we = bus.wr_en && wr_allowed;
        end
      end
      default: state_next = INIT;
    endcase
  end

  assign bus.wr_ready  = (state_reg == READY);
  assign bus.init_busy = (state_reg == INIT);
  assign bus.rd_a_vld  = vld_a_reg;
  assign bus.rd_b_vld  = vld_b_reg;

  map_ram_core #(.ADDR_BITS(ADDR_BITS), .VAL_BITS(VAL_BITS)) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .rd_a_en   (bus.rd_a_en),
    .rd_a_addr ({bus.rd_a_row, bus.rd_a_col}),
    .rd_a_data (core_a_data),
    .rd_b_en   (bus.rd_b_en),
    .rd_b_addr ({bus.rd_b_row, bus.rd_b_col}),
    .rd_b_data (core_b_data),
    .wr_en     (mem_we),
    .wr_addr   (mem_addr),
    .wr_data   (mem_data)
  );
endmodule

// File: tb/tb_map_ram.sv
// Directed bench for map_ram: init timing, read latency, collisions,
// init priority, reset mid-init and the MAP_RAM_BORDER_LOCK_EN edge lock.
module tb_map_ram;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] v;

  always #5 clk = ~clk;

  map_ram_if #(.COL_BITS(4), .ROW_BITS(4), .VAL_BITS(2)) mif ();

  map_ram #(.COL_BITS(4), .ROW_BITS(4), .VAL_BITS(2), .BORDER_VAL(1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (mif)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic wait_init(input string tag, input int exp_cycles);
    int n = 0;
    while (mif.init_busy === 1'b1 && n < 1000) begin
      tick();
      n++;
    end
    chk(tag, n, exp_cycles);
    chk({tag, "_rdy"}, int'(mif.wr_ready), 1);
  endtask

  task automatic read_a(input string tag, input int col, input int row, output logic [1:0] val);
    mif.rd_a_en = 1'b1; mif.rd_a_col = 4'(col); mif.rd_a_row = 4'(row);
    tick();
    mif.rd_a_en = 1'b0;
    chk({tag, "_vld"}, int'(mif.rd_a_vld), 1);
    val = mif.rd_a_val;
  endtask

  task automatic write(input int col, input int row, input int val);
    mif.wr_en = 1'b1; mif.wr_col = 4'(col); mif.wr_row = 4'(row); mif.wr_val = 2'(val);
    tick();
    mif.wr_en = 1'b0;
  endtask

  initial begin
    mif.rd_a_en = 0; mif.rd_a_col = 0; mif.rd_a_row = 0;
    mif.rd_b_en = 0; mif.rd_b_col = 0; mif.rd_b_row = 0;
    mif.wr_en = 0; mif.wr_col = 0; mif.wr_row = 0; mif.wr_val = 0;
    mif.init_req = 0;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", int'(mif.init_busy), 1);
    chk("rst_ready", int'(mif.wr_ready), 0);
    chk("rst_vld_a", int'(mif.rd_a_vld), 0);
    chk("rst_val_a", int'(mif.rd_a_val), 0);
    chk("rst_vld_b", int'(mif.rd_b_vld), 0);
    reset_n = 1'b1;
    wait_init("init_len", 256);

    read_a("r00", 0, 0, v);   chk("r00", int'(v), 1);
    read_a("r15_7", 15, 7, v); chk("r15_7", int'(v), 1);
    read_a("r7_15", 7, 15, v); chk("r7_15", int'(v), 1);
    read_a("r7_7", 7, 7, v);   chk("r7_7", int'(v), 0);

    // Latency: one strobe -> one valid cycle
    tick();
    read_a("lat", 13, 13, v); chk("lat_val", int'(v), 0);
    tick();
    chk("lat_vld_drop", int'(mif.rd_a_vld), 0);

    // Read-first collision on port B
    mif.rd_b_en = 1'b1; mif.rd_b_col = 4'd5; mif.rd_b_row = 4'd6;
    write(5, 6, 3);
    chk("coll_vld", int'(mif.rd_b_vld), 1);
    chk("coll_old", int'(mif.rd_b_val), 0);
    tick();
    mif.rd_b_en = 1'b0;
    chk("coll_new", int'(mif.rd_b_val), 3);
    read_a("coll_a", 5, 6, v); chk("coll_a", int'(v), 3);

    // Both ports on same cell
    mif.rd_b_en = 1'b1; mif.rd_b_col = 4'd5; mif.rd_b_row = 4'd6;
    read_a("dual", 5, 6, v);
    mif.rd_b_en = 1'b0;
    chk("dual_eq", int'(mif.rd_b_val), int'(v));

    // init_req beats a simultaneous write
    mif.init_req = 1'b1;
    write(9, 9, 2);
    mif.init_req = 1'b0;
    chk("prio_busy", int'(mif.init_busy), 1);
    chk("prio_ready", int'(mif.wr_ready), 0);
    repeat (40) tick();
    write(5, 1, 3);           // cell 21, already initialised: must stay 0
    wait_init("reinit_len", 215);
    read_a("r9_9", 9, 9, v); chk("r9_9", int'(v), 0);
    read_a("r5_1", 5, 1, v); chk("r5_1", int'(v), 0);
    read_a("r5_6", 5, 6, v); chk("r5_6_cleared", int'(v), 0);

    // Reset in the middle of init
    mif.init_req = 1'b1; tick(); mif.init_req = 1'b0;
    repeat (100) tick();
    reset_n = 1'b0; tick();
    chk("mid_rst_busy", int'(mif.init_busy), 1);
    reset_n = 1'b1;
    wait_init("mid_rst_len", 256);

    // Edge cells: locked or ordinary depending on build
    write(0, 4, 2);
    write(15, 15, 0);
    write(4, 4, 2);
    read_a("e0_4", 0, 4, v);
`ifdef MAP_RAM_BORDER_LOCK_EN
    chk("e0_4", int'(v), 1);
`else
    chk("e0_4", int'(v), 2);
`endif
    read_a("e15_15", 15, 15, v);
`ifdef MAP_RAM_BORDER_LOCK_EN
    chk("e15_15", int'(v), 1);
`else
    chk("e15_15", int'(v), 0);
`endif
    read_a("i4_4", 4, 4, v); chk("i4_4", int'(v), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
